// File: rtl/aux_capture.sv
// aux_capture: decimated capture of the AUX buses into a one-entry (address, value) write slot.
module aux_capture #(
    parameter int unsigned DECIM       = 1,
    parameter int unsigned MAX_SAMPLES = 24'hFFFFFF
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        Start,
    input  logic        Stop,
    input  logic        TrigOnChange,
    input  logic [7:0]  AUX_A,
    input  logic [14:0] AUX_B,
    input  logic        Ready,
    output logic        WrEn,
    output logic [23:0] Addr,
    output logic [31:0] Val,
    output logic        Busy,
    output logic        Done,
    output logic        Overrun,
    output logic [23:0] Count
);

    localparam int unsigned CW = 16;
    localparam int unsigned AW = 24;
    localparam int unsigned SW = 23;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   decim_cnt;
    logic [AW-1:0]   loaded;
    logic [SW-1:0]   prev;
    logic [SW-1:0]   cur_c;
    logic            xfer_c;
    logic            due_c;
    logic            start_c;

    // Next-state decode and sample-due qualification.
    always_comb begin
        state_nxt = state;
        due_c     = 1'b0;
        start_c   = 1'b0;
        cur_c     = {AUX_B, AUX_A};
        xfer_c    = WrEn && Ready;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start && !Stop) begin
                    start_c   = 1'b1;
                    state_nxt = TrigOnChange ? S_ARMED : S_RUN;
                end
            end
            S_ARMED: begin
                if (Stop) begin
                    state_nxt = S_DONE;
                end else if (cur_c != prev) begin
                    due_c     = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (Stop || (loaded == AW'(MAX_SAMPLES))) begin
                    state_nxt = S_DRAIN;
                end else begin
                    due_c = (decim_cnt == '0);
                end
            end
            S_DRAIN: begin
                if (!WrEn || xfer_c) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, decimation counter, output slot and status registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= S_IDLE;
            decim_cnt <= '0;
            loaded    <= '0;
            prev      <= '0;
            WrEn      <= 1'b0;
            Addr      <= '0;
            Val       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Overrun   <= 1'b0;
            Count     <= '0;
        end else begin
            state <= state_nxt;
            Busy  <= (state_nxt == S_ARMED) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            Done  <= (state_nxt == S_DONE);

            if (state == S_ARMED) begin
                prev <= cur_c;
            end

            // The trigger cycle counts as decimation slot 0.
            if (start_c) begin
                decim_cnt <= '0;
            end else if (state == S_ARMED && state_nxt == S_RUN) begin
                decim_cnt <= (DECIM == 1) ? '0 : CW'(1);
            end else if (state == S_RUN && state_nxt == S_RUN) begin
                decim_cnt <= (decim_cnt == CW'(DECIM - 1)) ? '0 : decim_cnt + CW'(1);
            end

            if (xfer_c) begin
                Count <= Count + AW'(1);
            end

            // Slot load / drop / drain; a transfer frees the slot for a same-cycle load.
            if (due_c && (!WrEn || xfer_c)) begin
                WrEn   <= 1'b1;
                Addr   <= loaded;
                Val    <= {9'b0, cur_c};
                loaded <= loaded + AW'(1);
            end else begin
                if (due_c) begin
                    Overrun <= 1'b1;
                end
                if (xfer_c) begin
                    WrEn <= 1'b0;
                end
            end

            if (start_c) begin
                Count   <= '0;
                Addr    <= '0;
                Overrun <= 1'b0;
                loaded  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aux_capture.sv
// tb_aux_capture: directed checks of aux_capture (two instances with different decimation/limit).
module tb_aux_capture;

    logic        CLK = 1'b0;
    logic        RES;
    logic        Start, Stop, TrigOnChange, Ready;
    logic [7:0]  AUX_A;
    logic [14:0] AUX_B;

    logic        we0, busy0, done0, ovr0;
    logic [23:0] addr0, cnt0;
    logic [31:0] val0;
    logic        we1, busy1, done1, ovr1;
    logic [23:0] addr1, cnt1;
    logic [31:0] val1;

    int vectors = 0;
    int errors  = 0;

    always #5 CLK = ~CLK;

    aux_capture #(.DECIM(1), .MAX_SAMPLES(4)) u0 (
        .CLK(CLK), .RES(RES), .Start(Start), .Stop(Stop), .TrigOnChange(TrigOnChange),
        .AUX_A(AUX_A), .AUX_B(AUX_B), .Ready(Ready),
        .WrEn(we0), .Addr(addr0), .Val(val0), .Busy(busy0), .Done(done0),
        .Overrun(ovr0), .Count(cnt0)
    );

    aux_capture #(.DECIM(4), .MAX_SAMPLES(3)) u1 (
        .CLK(CLK), .RES(RES), .Start(Start), .Stop(Stop), .TrigOnChange(TrigOnChange),
        .AUX_A(AUX_A), .AUX_B(AUX_B), .Ready(Ready),
        .WrEn(we1), .Addr(addr1), .Val(val1), .Busy(busy1), .Done(done1),
        .Overrun(ovr1), .Count(cnt1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RES = 1'b1; Start = 1'b0; Stop = 1'b0; TrigOnChange = 1'b0; Ready = 1'b0;
        AUX_A = '0; AUX_B = '0;
        tick();
        RES = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({we0, addr0, val0, busy0, done0, ovr0, cnt0} !== '0) begin
            errors++;
            $display("FAIL reset_u0: got we=%b addr=%h val=%h busy=%b done=%b ovr=%b cnt=%h, want all 0",
                     we0, addr0, val0, busy0, done0, ovr0, cnt0);
        end
        vectors++;
        if ({we1, addr1, val1, busy1, done1, ovr1, cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_u1: got we=%b addr=%h val=%h busy=%b done=%b ovr=%b cnt=%h, want all 0",
                     we1, addr1, val1, busy1, done1, ovr1, cnt1);
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        Start = 1'b1; Stop = 1'b1;
        tick();
        Start = 1'b0; Stop = 1'b0;
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || we0 !== 1'b0) begin
            errors++;
            $display("FAIL start_stop: got busy=%b done=%b we=%b, want 0 0 0", busy0, done0, we0);
        end
    endtask

    // DECIM=1, MAX=4: four back-to-back words, then DONE.
    task automatic test_back_to_back();
        logic        exp_we;
        logic [31:0] exp_val;
        do_reset();
        Ready = 1'b1; AUX_B = 15'h1234; AUX_A = 8'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_we  = (i <= 4);
            exp_val = 32'h0012_3400 | 32'(i - 1);
            vectors++;
            if (we0 !== exp_we) begin
                errors++;
                $display("FAIL b2b_wren[%0d]: got %b want %b", i, we0, exp_we);
            end
            if (exp_we) begin
                vectors++;
                if (addr0 !== 24'(i - 1) || val0 !== exp_val) begin
                    errors++;
                    $display("FAIL b2b_word[%0d]: got addr=%h val=%h want addr=%h val=%h",
                             i, addr0, val0, 24'(i - 1), exp_val);
                end
            end
            AUX_A = 8'(i);
        end
        vectors++;
        if (done0 !== 1'b1 || cnt0 !== 24'd4 || ovr0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got done=%b cnt=%0d ovr=%b busy=%b want 1 4 0 0",
                     done0, cnt0, ovr0, busy0);
        end
    endtask

    // DECIM=4, MAX=3: loads every fourth cycle.
    task automatic test_decim();
        logic        exp_we;
        logic [31:0] exp_val;
        do_reset();
        Ready = 1'b1; AUX_A = 8'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_we  = (i == 1) || (i == 5) || (i == 9);
            exp_val = 32'(i - 1);
            vectors++;
            if (we1 !== exp_we) begin
                errors++;
                $display("FAIL decim_wren[%0d]: got %b want %b", i, we1, exp_we);
            end
            if (exp_we) begin
                vectors++;
                if (addr1 !== 24'((i - 1) / 4) || val1 !== exp_val) begin
                    errors++;
                    $display("FAIL decim_word[%0d]: got addr=%h val=%h want addr=%h val=%h",
                             i, addr1, val1, 24'((i - 1) / 4), exp_val);
                end
            end
            if (i == 10) begin
                vectors++;
                if (done1 !== 1'b0) begin
                    errors++;
                    $display("FAIL decim_early_done: got %b want 0", done1);
                end
            end
            AUX_A = 8'(i);
        end
        vectors++;
        if (done1 !== 1'b1 || cnt1 !== 24'd3) begin
            errors++;
            $display("FAIL decim_end: got done=%b cnt=%0d want 1 3", done1, cnt1);
        end
    endtask

    // Wait in ARMED until the inputs change; the change cycle is sample 0.
    task automatic test_trigger();
        do_reset();
        Ready = 1'b1; TrigOnChange = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        vectors++;
        if (we0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL trig_armed: got we=%b busy=%b want 0 1", we0, busy0);
        end
        AUX_A = 8'h11;
        tick();
        vectors++;
        if (we0 !== 1'b1 || addr0 !== 24'd0 || val0 !== 32'h0000_0011) begin
            errors++;
            $display("FAIL trig_fire: got we=%b addr=%h val=%h want 1 000000 00000011",
                     we0, addr0, val0);
        end
    endtask

    // Stalled sink: slot holds, later samples dropped, no address gap.
    task automatic test_overrun();
        do_reset();
        AUX_A = 8'd5; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        AUX_A = 8'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (we0 !== 1'b1 || addr0 !== 24'd0 || val0 !== 32'd5 || ovr0 !== 1'b1) begin
                errors++;
                $display("FAIL ovr_hold[%0d]: got we=%b addr=%h val=%h ovr=%b want 1 0 5 1",
                         i, we0, addr0, val0, ovr0);
            end
        end
        Ready = 1'b1;
        tick();
        vectors++;
        if (we0 !== 1'b1 || addr0 !== 24'd1 || val0 !== 32'd6 || cnt0 !== 24'd1 || ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_resume: got we=%b addr=%h val=%h cnt=%0d ovr=%b want 1 1 6 1 1",
                     we0, addr0, val0, cnt0, ovr0);
        end
    endtask

    // Stop with a full, stalled slot: drain then DONE.
    task automatic test_stop_drain();
        do_reset();
        AUX_A = 8'h22; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        tick();
        vectors++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || we0 !== 1'b1 || ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold: got busy=%b done=%b we=%b ovr=%b want 1 0 1 0",
                     busy0, done0, we0, ovr0);
        end
        Ready = 1'b1;
        tick();
        vectors++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 24'd1 || we0 !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: got done=%b busy=%b cnt=%0d we=%b want 1 0 1 0",
                     done0, busy0, cnt0, we0);
        end
        tick();
        tick();
        vectors++;
        if (we0 !== 1'b0 || cnt0 !== 24'd1) begin
            errors++;
            $display("FAIL drain_quiet: got we=%b cnt=%0d want 0 1", we0, cnt0);
        end
    endtask

    // Reset mid-transfer wipes everything and suppresses the transfer.
    task automatic test_reset_mid();
        do_reset();
        Ready = 1'b1; AUX_A = 8'h33; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        vectors++;
        if (we0 !== 1'b1 || cnt0 !== 24'd1) begin
            errors++;
            $display("FAIL rstmid_pre: got we=%b cnt=%0d want 1 1", we0, cnt0);
        end
        RES = 1'b1;
        tick();
        RES = 1'b0;
        vectors++;
        if ({we0, addr0, val0, busy0, done0, ovr0, cnt0} !== '0) begin
            errors++;
            $display("FAIL rstmid_post: got we=%b addr=%h val=%h busy=%b done=%b ovr=%b cnt=%h want all 0",
                     we0, addr0, val0, busy0, done0, ovr0, cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_back_to_back();
        test_decim();
        test_trigger();
        test_overrun();
        test_stop_drain();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
